// File: rtl/phase_timer_ctrl.sv
// Four-phase countdown sequencer driven by the 0.1 s strobe.
// Each phase loads a 7-bit tenths countdown and steps 0->1->2->3, once or looping.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | not sequencing, phase=0, countdown=0
// ST_RUN    | counting down on each tick
// ST_PAUSED | countdown and phase frozen until pause drops
module phase_timer_ctrl #(
  parameter int unsigned PH0_TENTHS = 120,
  parameter int unsigned PH1_TENTHS = 30,
  parameter int unsigned PH2_TENTHS = 90,
  parameter int unsigned PH3_TENTHS = 30,
  parameter bit          LOOP       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic       active,
  output logic       paused,
  output logic [1:0] phase,
  output logic [6:0] countdown,
  output logic       phase_done,
  output logic       seq_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  // A zero-length phase loads as one tick so the countdown never sits at 0 while running.
  localparam logic [6:0] D0 = (PH0_TENTHS == 0) ? 7'd1 : 7'(PH0_TENTHS);
  localparam logic [6:0] D1 = (PH1_TENTHS == 0) ? 7'd1 : 7'(PH1_TENTHS);
  localparam logic [6:0] D2 = (PH2_TENTHS == 0) ? 7'd1 : 7'(PH2_TENTHS);
  localparam logic [6:0] D3 = (PH3_TENTHS == 0) ? 7'd1 : 7'(PH3_TENTHS);

  state_t     r_state;
  logic       r_active;
  logic       r_paused;
  logic [1:0] r_phase;
  logic [6:0] r_countdown;
  logic       r_phase_done;
  logic       r_seq_done;
  logic [6:0] w_dur_next;

  // Duration of the phase that follows the current one.
  always_comb begin
    w_dur_next = D0;
    case (r_phase)
      2'd0:    w_dur_next = D1;
      2'd1:    w_dur_next = D2;
      2'd2:    w_dur_next = D3;
      default: w_dur_next = D0;
    endcase
  end

  // Sequencer FSM; priority abort > start > pause > tick, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_active     <= 1'b0;
      r_paused     <= 1'b0;
      r_phase      <= 2'd0;
      r_countdown  <= 7'd0;
      r_phase_done <= 1'b0;
      r_seq_done   <= 1'b0;
    end else begin
      r_phase_done <= 1'b0;
      r_seq_done   <= 1'b0;
      if (abort) begin
        r_state     <= ST_IDLE;
        r_active    <= 1'b0;
        r_paused    <= 1'b0;
        r_phase     <= 2'd0;
        r_countdown <= 7'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_phase     <= 2'd0;
              r_countdown <= D0;
              r_active    <= 1'b1;
              if (pause) begin
                r_state  <= ST_PAUSED;
                r_paused <= 1'b1;
              end else begin
                r_state  <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              r_state  <= ST_PAUSED;
              r_paused <= 1'b1;
            end else if (tick) begin
              if (r_countdown > 7'd1) begin
                r_countdown <= r_countdown - 7'd1;
              end else begin
                r_phase_done <= 1'b1;
                if (r_phase != 2'd3) begin
                  r_phase     <= r_phase + 2'd1;
                  r_countdown <= w_dur_next;
                end else if (LOOP) begin
                  r_phase     <= 2'd0;
                  r_countdown <= D0;
                end else begin
                  r_state     <= ST_IDLE;
                  r_active    <= 1'b0;
                  r_phase     <= 2'd0;
                  r_countdown <= 7'd0;
                  r_seq_done  <= 1'b1;
                end
              end
            end
          end
          ST_PAUSED: begin
            // A tick coincident with release is dropped; counting resumes on the next one.
            if (!pause) begin
              r_state  <= ST_RUN;
              r_paused <= 1'b0;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_active    <= 1'b0;
            r_paused    <= 1'b0;
            r_phase     <= 2'd0;
            r_countdown <= 7'd0;
          end
        endcase
      end
    end
  end

  assign active     = r_active;
  assign paused     = r_paused;
  assign phase      = r_phase;
  assign countdown  = r_countdown;
  assign phase_done = r_phase_done;
  assign seq_done   = r_seq_done;

endmodule

// File: tb/tb_phase_timer_ctrl.sv
// Bench for phase_timer_ctrl: three configurations share one stimulus stream and
// are each compared every cycle against an elapsed-ticks reference model.
module tb_phase_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;

  logic       act [3];
  logic       pau [3];
  logic [1:0] ph  [3];
  logic [6:0] cd  [3];
  logic       pd  [3];
  logic       sd  [3];

  int n_vec = 0;
  int n_err = 0;
  int pd_cnt_a = 0;
  int sd_cnt_a = 0;

  always #5 clk = ~clk;

  // A: single pass, B: looping, C: looping with a zero-length phase 1
  phase_timer_ctrl #(.PH0_TENTHS(3), .PH1_TENTHS(2), .PH2_TENTHS(1), .PH3_TENTHS(2), .LOOP(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause), .abort(abort),
    .active(act[0]), .paused(pau[0]), .phase(ph[0]), .countdown(cd[0]),
    .phase_done(pd[0]), .seq_done(sd[0]));
  phase_timer_ctrl #(.PH0_TENTHS(3), .PH1_TENTHS(2), .PH2_TENTHS(1), .PH3_TENTHS(2), .LOOP(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause), .abort(abort),
    .active(act[1]), .paused(pau[1]), .phase(ph[1]), .countdown(cd[1]),
    .phase_done(pd[1]), .seq_done(sd[1]));
  phase_timer_ctrl #(.PH0_TENTHS(3), .PH1_TENTHS(0), .PH2_TENTHS(1), .PH3_TENTHS(2), .LOOP(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause), .abort(abort),
    .active(act[2]), .paused(pau[2]), .phase(ph[2]), .countdown(cd[2]),
    .phase_done(pd[2]), .seq_done(sd[2]));

  // reference model: phase index plus ticks elapsed within it
  int m_par [3][4] = '{'{3, 2, 1, 2}, '{3, 2, 1, 2}, '{3, 0, 1, 2}};
  bit m_loop[3]    = '{1'b0, 1'b1, 1'b1};
  bit m_act [3];
  bit m_pau [3];
  bit m_pd  [3];
  bit m_sd  [3];
  int m_ph  [3];
  int m_el  [3];

  function automatic int dur(input int i, input int p);
    return (m_par[i][p] == 0) ? 1 : m_par[i][p];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_pau[i] = 0; m_pd[i] = 0; m_sd[i] = 0; m_ph[i] = 0; m_el[i] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit p, input bit a, input bit t);
    for (int i = 0; i < 3; i++) begin
      m_pd[i] = 0;
      m_sd[i] = 0;
      if (a) begin
        m_act[i] = 0; m_pau[i] = 0; m_ph[i] = 0; m_el[i] = 0;
      end else if (!m_act[i]) begin
        if (s) begin
          m_act[i] = 1; m_pau[i] = p; m_ph[i] = 0; m_el[i] = 0;
        end
      end else if (m_pau[i]) begin
        if (!p) m_pau[i] = 0;
      end else if (p) begin
        m_pau[i] = 1;
      end else if (t) begin
        m_el[i]++;
        if (m_el[i] == dur(i, m_ph[i])) begin
          m_pd[i] = 1;
          m_el[i] = 0;
          if (m_ph[i] == 3 && !m_loop[i]) begin
            m_sd[i] = 1; m_act[i] = 0;
          end
          m_ph[i] = (m_ph[i] + 1) % 4;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    string nm;
    for (int i = 0; i < 3; i++) begin
      nm = (i == 0) ? "A" : (i == 1) ? "B" : "C";
      chk({nm, ".active"},     32'(act[i]), 32'(m_act[i]));
      chk({nm, ".paused"},     32'(pau[i]), 32'(m_pau[i]));
      chk({nm, ".phase"},      32'(ph[i]),  m_act[i] ? 32'(m_ph[i]) : 32'd0);
      chk({nm, ".countdown"},  32'(cd[i]),  m_act[i] ? 32'(dur(i, m_ph[i]) - m_el[i]) : 32'd0);
      chk({nm, ".phase_done"}, 32'(pd[i]),  32'(m_pd[i]));
      chk({nm, ".seq_done"},   32'(sd[i]),  32'(m_sd[i]));
    end
  endtask

  // drive one cycle of inputs, step the model at the edge, compare 1 ns later
  task automatic cycle(input bit s, input bit p, input bit a, input bit t);
    start = s; pause = p; abort = a; tick = t;
    @(posedge clk);
    model_step(s, p, a, t);
    #1;
    check_all();
    if (pd[0]) pd_cnt_a++;
    if (sd[0]) sd_cnt_a++;
  endtask

  task automatic tick_gap(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
    end
  endtask

  initial begin
    bit rp;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);

    // single pass / loop: 8 ticks, one every 4 clocks
    cycle(1, 0, 0, 0);
    chk("A.start_cd", 32'(cd[0]), 32'd3);
    pd_cnt_a = 0; sd_cnt_a = 0;
    tick_gap(8);
    chk("A.pd_count", 32'(pd_cnt_a), 32'd4);
    chk("A.sd_count", 32'(sd_cnt_a), 32'd1);
    chk("A.end_cd",   32'(cd[0]), 32'd0);
    chk("B.loop_cd",  32'(cd[1]), 32'd3);
    chk("B.loop_act", 32'(act[1]), 32'd1);
    chk("C.loop_cd",  32'(cd[2]), 32'd2);

    // pause in phase 1 at countdown 2, release with a coincident tick
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    tick_gap(3);
    chk("A.pre_pause_ph", 32'(ph[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 0, 1);
      cycle(0, 1, 0, 0);
    end
    chk("A.paused_cd", 32'(cd[0]), 32'd2);
    cycle(0, 0, 0, 1);
    chk("A.release_cd", 32'(cd[0]), 32'd2);
    cycle(0, 0, 0, 1);
    chk("A.resume_cd", 32'(cd[0]), 32'd1);

    // start while running is ignored
    cycle(1, 0, 0, 0);
    chk("A.restart_cd", 32'(cd[0]), 32'd1);
    chk("A.restart_ph", 32'(ph[0]), 32'd1);

    // abort coincident with an expiring tick in phase 2
    cycle(0, 0, 0, 1);
    chk("A.ph2_cd", 32'(cd[0]), 32'd1);
    cycle(0, 0, 1, 1);
    chk("A.abort_pd",  32'(pd[0]), 32'd0);
    chk("A.abort_act", 32'(act[0]), 32'd0);

    // start and abort together in idle
    cycle(1, 0, 1, 0);
    chk("A.start_abort_act", 32'(act[0]), 32'd0);

    // async reset between edges mid-run
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);

    // randomized traffic
    rp = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) rp = ~rp;
      cycle($urandom_range(0, 7) == 0, rp, $urandom_range(0, 63) == 0,
            $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
